axi4_stream_pkt_arbiter: RTL and testbench

- Packet-level round-robin arbiter for CH_AMOUNT AXI4-Stream sources, normally the output ports of SMART-mode packet FIFOs, merged onto one AXI4-Stream master.
- A grant is issued only when a source holds at least one complete packet, using each FIFO's pkts_amount_o != 0 as pkt_avail_i.
- The grant stays locked from the first beat until the tlast handshake, so packets are never interleaved.
- Sits between per-port FIFOs and a shared egress datapath (MAC, DMA, packet parser).

---
 rtl/axi4_stream_pkt_arbiter_if.sv | 20 ++
 rtl/axi4_stream_pkt_arbiter.sv | 125 ++++++++++++
 tb/tb_axi4_stream_pkt_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_stream_pkt_arbiter_if.sv
// AXI4-Stream bundle shared by the packet arbiter's inputs and output.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TID_WIDTH   = 1
);
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic                     tlast;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic [TDEST_WIDTH-1:0]   tdest;
  logic [TID_WIDTH-1:0]     tid;
  logic                     tvalid;
  logic                     tready;

  modport master (output tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid, input tready);
  modport slave  (input tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid, output tready);
endinterface

// File: rtl/axi4_stream_pkt_arbiter.sv
// Packet-level round-robin arbiter: merges CH_AMOUNT AXI4-Stream sources onto one
// master, locking the grant from the first beat until the tlast handshake.
module axi4_stream_pkt_arbiter #(
  parameter int TDATA_WIDTH   = 32,
  parameter int TUSER_WIDTH   = 1,
  parameter int TDEST_WIDTH   = 1,
  parameter int TID_WIDTH     = 1,
  parameter int CH_AMOUNT     = 4,
  parameter int CH_WIDTH      = (CH_AMOUNT > 1) ? $clog2(CH_AMOUNT) : 1,
  parameter bit USE_PKT_AVAIL = 1'b1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CH_AMOUNT-1:0] pkt_avail_i,
  axi4_stream_if.slave         pkt_i [CH_AMOUNT],
  axi4_stream_if.master        pkt_o,
  output logic [CH_WIDTH-1:0]  grant_o,
  output logic                 busy_o,
  output logic                 pkt_done_o,
  output logic [CNT_WIDTH-1:0] pkt_cnt_o
);

  localparam int                  KEEP_WIDTH = TDATA_WIDTH / 8;
  localparam logic [CH_WIDTH-1:0] LAST_CH    = CH_WIDTH'(CH_AMOUNT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic [CH_WIDTH-1:0] grant_nxt;
  logic [CH_WIDTH-1:0] winner;
  logic                xfer_last;

  logic [TDATA_WIDTH-1:0] ch_tdata [CH_AMOUNT];
  logic [KEEP_WIDTH-1:0]  ch_tstrb [CH_AMOUNT];
  logic [KEEP_WIDTH-1:0]  ch_tkeep [CH_AMOUNT];
  logic [TUSER_WIDTH-1:0] ch_tuser [CH_AMOUNT];
  logic [TDEST_WIDTH-1:0] ch_tdest [CH_AMOUNT];
  logic [TID_WIDTH-1:0]   ch_tid   [CH_AMOUNT];
  logic [CH_AMOUNT-1:0]   ch_tvalid;
  logic [CH_AMOUNT-1:0]   ch_tlast;
  logic [CH_AMOUNT-1:0]   ch_tready;
  logic [CH_AMOUNT-1:0]   req;

  // Interface arrays only accept constant indices, so flatten them into plain arrays.
  for (genvar g = 0; g < CH_AMOUNT; g++) begin : g_ch
    assign ch_tdata[g]    = pkt_i[g].tdata;
    assign ch_tstrb[g]    = pkt_i[g].tstrb;
    assign ch_tkeep[g]    = pkt_i[g].tkeep;
    assign ch_tuser[g]    = pkt_i[g].tuser;
    assign ch_tdest[g]    = pkt_i[g].tdest;
    assign ch_tid[g]      = pkt_i[g].tid;
    assign ch_tvalid[g]   = pkt_i[g].tvalid;
    assign ch_tlast[g]    = pkt_i[g].tlast;
    assign pkt_i[g].tready = ch_tready[g];
  end

  assign req = ch_tvalid & (pkt_avail_i | {CH_AMOUNT{!USE_PKT_AVAIL}});

  // Round-robin scan starting after the last grant and ending on it.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    winner = grant_o;
    for (int k = CH_AMOUNT; k >= 1; k--) begin
      int idx;
      idx = (int'(grant_o) + k) % CH_AMOUNT;
      if (req[idx]) winner = CH_WIDTH'(idx);
    end
  end

  // Data fields always follow the granted channel; tvalid is gated by the FSM
  // and never depends on pkt_o.tready.
  assign pkt_o.tdata  = ch_tdata[grant_o];
  assign pkt_o.tstrb  = ch_tstrb[grant_o];
  assign pkt_o.tkeep  = ch_tkeep[grant_o];
  assign pkt_o.tuser  = ch_tuser[grant_o];
  assign pkt_o.tdest  = ch_tdest[grant_o];
  assign pkt_o.tid    = ch_tid[grant_o];
  assign pkt_o.tlast  = ch_tlast[grant_o];
  assign pkt_o.tvalid = (state == XFER) && ch_tvalid[grant_o];

  assign busy_o    = (state == XFER);
  assign xfer_last = pkt_o.tvalid && pkt_o.tready && pkt_o.tlast;

  always_comb begin
    ch_tready = '0;
    if (state == XFER) ch_tready[grant_o] = pkt_o.tready;
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_o;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = XFER;
          grant_nxt = winner;
        end
      end
      XFER: begin
        if (xfer_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments and resets asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      grant_o    <= LAST_CH;
      pkt_done_o <= 1'b0;
      pkt_cnt_o  <= '0;
    end else begin
      state      <= state_nxt;
      grant_o    <= grant_nxt;
      pkt_done_o <= xfer_last;
      if (xfer_last) pkt_cnt_o <= pkt_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_axi4_stream_pkt_arbiter.sv
// Directed bench for axi4_stream_pkt_arbiter: a 4-channel instance for ordering,
// locking, backpressure and reset, plus a 1-channel 2-bit-counter instance for wrap.
module tb_axi4_stream_pkt_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- 4-channel instance ----------------
  axi4_stream_if #(.TDATA_WIDTH(32), .TID_WIDTH(2)) s_if [4] ();
  axi4_stream_if #(.TDATA_WIDTH(32), .TID_WIDTH(2)) o_if ();

  logic [3:0]  avail    = 4'h0;
  logic        sink_rdy = 1'b1;
  logic [1:0]  grant;
  logic        busy;
  logic        done;
  logic [15:0] cnt;

  logic [31:0] q_data [4][64];
  logic        q_last [4][64];
  logic [5:0]  q_wr   [4] = '{default: 6'd0};
  logic [5:0]  q_rd   [4] = '{default: 6'd0};
  logic [3:0]  hs;
  logic [3:0]  s_tready;

  for (genvar g = 0; g < 4; g++) begin : g_src
    assign s_if[g].tvalid = (q_rd[g] != q_wr[g]);
    assign s_if[g].tdata  = q_data[g][q_rd[g]];
    assign s_if[g].tlast  = q_last[g][q_rd[g]];
    assign s_if[g].tstrb  = 4'hF;
    assign s_if[g].tkeep  = 4'hF;
    assign s_if[g].tuser  = 1'b0;
    assign s_if[g].tdest  = 1'b0;
    assign s_if[g].tid    = 2'(g);
    assign s_tready[g]    = s_if[g].tready;
    assign hs[g]          = s_if[g].tvalid && s_if[g].tready;
  end
  assign o_if.tready = sink_rdy;

  axi4_stream_pkt_arbiter #(
    .TDATA_WIDTH(32), .TUSER_WIDTH(1), .TDEST_WIDTH(1), .TID_WIDTH(2),
    .CH_AMOUNT(4), .USE_PKT_AVAIL(1'b1), .CNT_WIDTH(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .pkt_avail_i(avail), .pkt_i(s_if), .pkt_o(o_if),
    .grant_o(grant), .busy_o(busy), .pkt_done_o(done), .pkt_cnt_o(cnt)
  );

  // ---------------- 1-channel, 2-bit counter instance ----------------
  axi4_stream_if #(.TDATA_WIDTH(32)) b_s_if [1] ();
  axi4_stream_if #(.TDATA_WIDTH(32)) b_o_if ();

  logic [3:0] b_wr = 4'd0;
  logic [3:0] b_rd = 4'd0;
  logic [0:0] b_grant;
  logic       b_busy;
  logic       b_done;
  logic [1:0] b_cnt;

  assign b_s_if[0].tvalid = (b_rd != b_wr);
  assign b_s_if[0].tdata  = {28'd0, b_rd};
  assign b_s_if[0].tlast  = 1'b1;
  assign b_s_if[0].tstrb  = 4'hF;
  assign b_s_if[0].tkeep  = 4'hF;
  assign b_s_if[0].tuser  = 1'b0;
  assign b_s_if[0].tdest  = 1'b0;
  assign b_s_if[0].tid    = 1'b0;
  assign b_o_if.tready    = 1'b1;

  axi4_stream_pkt_arbiter #(
    .TDATA_WIDTH(32), .CH_AMOUNT(1), .CNT_WIDTH(2)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .pkt_avail_i(1'b1), .pkt_i(b_s_if), .pkt_o(b_o_if),
    .grant_o(b_grant), .busy_o(b_busy), .pkt_done_o(b_done), .pkt_cnt_o(b_cnt)
  );

  // ---------------- monitors ----------------
  int          cyc    = 0;
  logic [7:0]  out_n  = 8'd0;
  int          done_n = 0;
  logic [31:0] out_data [256];
  logic [1:0]  out_tid  [256];
  int          out_cyc  [256];
  int          b_done_n = 0;
  int          b_out_n  = 0;
  logic [1:0]  b_cnt_log [16];
  int          b_out_cyc [16];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++) if (hs[i]) q_rd[i] <= q_rd[i] + 6'd1;
    if (o_if.tvalid && o_if.tready) begin
      out_data[out_n] <= o_if.tdata;
      out_tid[out_n]  <= o_if.tid;
      out_cyc[out_n]  <= cyc + 1;
      out_n           <= out_n + 8'd1;
    end
    if (done) done_n <= done_n + 1;
    if (b_s_if[0].tvalid && b_s_if[0].tready) begin
      b_rd              <= b_rd + 4'd1;
      b_out_cyc[b_out_n] <= cyc + 1;
      b_out_n           <= b_out_n + 1;
    end
    if (b_done) begin
      b_cnt_log[b_done_n] <= b_cnt;
      b_done_n            <= b_done_n + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] beat_word(input int tag, input int b);
    return {tag[15:0], b[15:0]};
  endfunction

  task automatic add_pkt(input int ch, input int tag, input int len);
    for (int b = 0; b < len; b++) begin
      q_data[ch][q_wr[ch]] = beat_word(tag, b);
      q_last[ch][q_wr[ch]] = (b == len - 1);
      q_wr[ch]             = q_wr[ch] + 6'd1;
    end
  endtask

  task automatic check_pkt(input string tag, input int start, input int ch,
                           input int ptag, input int first, input int len);
    for (int b = 0; b < len; b++) begin
      check({tag, "_tid"}, 64'(out_tid[start + b]), 64'(ch));
      check({tag, "_data"}, 64'(out_data[start + b]), 64'(beat_word(ptag, first + b)));
    end
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int k = 0;
    while (done_n < target && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_done_count"}, 64'(done_n), 64'(target));
  endtask

  task automatic wait_beats(input string tag, input int target, input int budget);
    int k = 0;
    while (int'(out_n) < target && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_beat_count"}, 64'(out_n), 64'(target));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, d0, c0, seen, bad;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 64'(grant), 64'd3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cnt", 64'(cnt), 64'd0);
    check("rst_tvalid", 64'(o_if.tvalid), 64'd0);
    check("rst_tready", 64'(s_tready), 64'd0);
    check("rst_b_grant", 64'(b_grant), 64'd0);
    check("rst_b_cnt", 64'(b_cnt), 64'd0);
    tick();
    rst = 1'b0;
    avail = 4'hF;
    tick();
    @(negedge clk);
    check("idle_avail_no_valid", 64'(o_if.tvalid), 64'd0);
    tick();

    // Test 1: four 3-beat packets, round-robin order ch0..ch3
    base = int'(out_n); d0 = done_n; c0 = cyc;
    for (int ch = 0; ch < 4; ch++) add_pkt(ch, 16'h10 + ch, 3);
    wait_done("t1", d0 + 4, 60);
    for (int ch = 0; ch < 4; ch++) check_pkt("t1", base + 3 * ch, ch, 16'h10 + ch, 0, 3);
    check("t1_first_beat_cyc", 64'(out_cyc[base] - c0), 64'd2);
    check("t1_last_beat_cyc", 64'(out_cyc[base + 11] - c0), 64'd16);
    @(negedge clk);
    check("t1_cnt", 64'(cnt), 64'd4);
    tick();

    // Test 2: ch1 held off by pkt_avail for 10 cycles
    avail = 4'b1101;
    base = int'(out_n); d0 = done_n; seen = 0;
    add_pkt(1, 16'h20, 5);
    repeat (10) begin
      @(negedge clk);
      if (o_if.tvalid) seen++;
      tick();
    end
    check("t2_no_valid_while_unavail", 64'(seen), 64'd0);
    avail = 4'hF;
    @(negedge clk);
    check("t2_valid_same_cycle", 64'(o_if.tvalid), 64'd0);
    tick();
    @(negedge clk);
    check("t2_valid_next_cycle", 64'(o_if.tvalid), 64'd1);
    check("t2_grant", 64'(grant), 64'd1);
    wait_done("t2", d0 + 1, 30);
    check_pkt("t2", base, 1, 16'h20, 0, 5);
    @(negedge clk);
    check("t2_cnt", 64'(cnt), 64'd5);
    tick();

    // Test 3: ch0 requests mid-packet of ch2; lock holds
    base = int'(out_n); d0 = done_n;
    add_pkt(2, 16'h30, 6);
    wait_beats("t3_mid", base + 2, 20);
    add_pkt(0, 16'h31, 3);
    wait_done("t3", d0 + 2, 60);
    check_pkt("t3_ch2", base, 2, 16'h30, 0, 6);
    check_pkt("t3_ch0", base + 6, 0, 16'h31, 0, 3);
    tick();

    // Test 4: backpressure toggling on a 4-beat ch3 packet
    base = int'(out_n); d0 = done_n; bad = 0;
    add_pkt(3, 16'h40, 4);
    for (int k = 0; k < 10; k++) begin
      tick();
      sink_rdy = (k % 2 == 0);
      @(negedge clk);
      if (busy) begin
        if (s_tready[3] !== sink_rdy) bad++;
        if (s_tready[2:0] !== 3'b000) bad++;
      end else if (s_tready !== 4'b0000) begin
        bad++;
      end
    end
    check("t4_handshakes", 64'(int'(out_n) - base), 64'd4);
    check("t4_tready_mirror", 64'(bad), 64'd0);
    tick();
    sink_rdy = 1'b1;
    wait_done("t4", d0 + 1, 20);
    check_pkt("t4", base, 3, 16'h40, 0, 4);
    tick();

    // Test 5: reset during beat 2 of a ch1 packet
    base = int'(out_n); d0 = done_n;
    add_pkt(1, 16'h50, 4);
    wait_beats("t5_mid", base + 2, 20);
    rst = 1'b1;
    add_pkt(0, 16'h51, 3);
    @(negedge clk);
    check("t5_rst_grant", 64'(grant), 64'd3);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_cnt", 64'(cnt), 64'd0);
    check("t5_rst_tvalid", 64'(o_if.tvalid), 64'd0);
    check("t5_rst_tready", 64'(s_tready), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("t5_grant_after_rst", 64'(grant), 64'd0);
    check("t5_busy_after_rst", 64'(busy), 64'd1);
    wait_done("t5", d0 + 2, 40);
    check_pkt("t5_ch0", base + 2, 0, 16'h51, 0, 3);
    check_pkt("t5_ch1_tail", base + 5, 1, 16'h50, 2, 2);
    @(negedge clk);
    check("t5_cnt", 64'(cnt), 64'd2);
    tick();

    // Test 6: single channel, 2-bit counter wrap with single-beat packets
    b_wr = 4'd5;
    for (int k = 0; k < 40 && b_done_n < 5; k++) tick();
    check("t6_done_count", 64'(b_done_n), 64'd5);
    check("t6_cnt0", 64'(b_cnt_log[0]), 64'd1);
    check("t6_cnt1", 64'(b_cnt_log[1]), 64'd2);
    check("t6_cnt2", 64'(b_cnt_log[2]), 64'd3);
    check("t6_cnt3", 64'(b_cnt_log[3]), 64'd0);
    check("t6_cnt4", 64'(b_cnt_log[4]), 64'd1);
    check("t6_beat_spacing", 64'(b_out_cyc[1] - b_out_cyc[0]), 64'd2);
    check("t6_grant", 64'(b_grant), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
